render_scheduler: RTL and testbench
===================================

RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 SHALL have parameter H_PIX, default 320, pixels per stored row.
REQ-002 SHALL have parameter V_PIX, default 240, stored rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-004 SHALL have parameter PIX_W, default 12, pixel width (4:4:4 RGB).
REQ-005 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a frame render.
REQ-008 SHALL have port disp_req  in  1  display owns the frame-buffer port this cycle.
REQ-009 SHALL have port disp_addr  in  ADDR_W  display read address.
REQ-010 SHALL have port shade_start  out  1  one-cycle pulse launching the shading datapath.
REQ-011 SHALL have port shade_x  out  9  pixel column of the launched ray.
REQ-012 SHALL have port shade_y  out  9  pixel row of the launched ray.
REQ-013 SHALL have port shade_done  in  1  datapath result valid, one-cycle pulse.
REQ-014 SHALL have port shade_pixel  in  PIX_W  datapath colour result.
REQ-015 SHALL have port mem_we  out  1  frame-buffer write enable.
REQ-016 SHALL have port mem_addr  out  ADDR_W  frame-buffer address (read or write).
REQ-017 SHALL have port mem_din  out  PIX_W  frame-buffer write data.
REQ-018 SHALL have port busy  out  1  high from accepted start until frame complete.
REQ-019 SHALL have port frame_done  out  1  sticky flag, high once a full frame is stored.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-021 IDLE: start -> ISSUE with x=0, y=0, frame_done cleared; start in any other state ignored.
REQ-022 ISSUE: shade_start=1 for exactly one cycle with shade_x=x, shade_y=y; next state WAIT.
REQ-023 WAIT: on shade_done capture shade_pixel into write buffer, go WRITE; shade_done outside WAIT ignored.
REQ-024 WRITE: if disp_req=0, mem_we=1, mem_addr=y*H_PIX+x, mem_din=buffer, then advance; if disp_req=1, stall with mem_we=0.
REQ-025 Advance: x==H_PIX-1 -> x=0, y=y+1; else x=x+1; last pixel (H_PIX-1, V_PIX-1) -> DONE, else ISSUE.
REQ-026 DONE: frame_done=1, busy=0; behaviour per Configuration.
REQ-027 mem_addr SHALL equal disp_addr whenever mem_we=0; display has absolute priority, mem_we never asserted while disp_req=1.
REQ-028 Address arithmetic SHALL be unsigned, ADDR_W bits; max address H_PIX*V_PIX-1 (76799 at defaults).
REQ-029 Minimum per-pixel cost: ISSUE 1 + WAIT >=1 + WRITE >=1 cycles; shade_done in first WAIT cycle allowed.
REQ-030 busy SHALL be 1 in ISSUE, WAIT, WRITE; 0 in IDLE, DONE.

Reset
REQ-031 On rst: state IDLE, x=0, y=0, buffer=0, shade_start=0, mem_we=0, mem_din=0, busy=0, frame_done=0; mem_addr follows disp_addr.
REQ-032 Reset mid-frame SHALL abort immediately; any later shade_done is ignored until a new start.

Configuration
REQ-033 Macro RENDER_CONTINUOUS_EN: defined -> DONE returns to ISSUE next cycle with x=y=0, frame_done stays 1, busy returns 1; undefined -> DONE holds until start, then behaves as IDLE start.

Verification
REQ-034 Reset, start, shade_done 2 cycles after each shade_start, disp_req=0 -> 76800 writes, addresses 0..76799 in order, frame_done=1.
REQ-035 disp_req=1 for 5 cycles while in WRITE -> mem_we=0 those 5 cycles, mem_addr=disp_addr, write occurs on first disp_req=0 cycle.
REQ-036 Pixel (319,0) completes -> next shade_x=0, shade_y=1, write address 319 then 320.
REQ-037 rst asserted in WAIT at (10,5), then shade_done pulse -> no write, state IDLE, busy=0.
REQ-038 Spurious shade_done in IDLE and second start during busy -> no write, no extra shade_start, sequence unchanged.
REQ-039 Last pixel written with RENDER_CONTINUOUS_EN defined -> shade_start at (0,0) two cycles later; undefined -> idle until start.

Source files
------------

// File: rtl/render_scheduler.sv
// render_scheduler
// Walks a frame one pixel at a time. For each pixel it launches the shading
// datapath, waits for the colour result, and then writes it into the frame
// buffer. The display always has priority on the shared frame-buffer port:
// a pending pixel write simply waits until the display releases the port.
//
// Optional feature (macro RENDER_CONTINUOUS_EN):
//   defined   - after the last pixel the scheduler restarts at (0,0) on its own
//   undefined - after the last pixel it holds in DONE until the next start
//
// Parameters
//   H_PIX   pixels per stored row
//   V_PIX   stored rows per frame
//   ADDR_W  frame-buffer address width
//   PIX_W   pixel width (4:4:4 RGB)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse that begins a frame render
//   disp_req          display owns the frame-buffer port this cycle
//   disp_addr         display read address
//   shade_start       one-cycle launch pulse to the shading datapath
//   shade_x, shade_y  pixel coordinate of the launched ray
//   shade_done        datapath result valid (one-cycle pulse)
//   shade_pixel       datapath colour result
//   mem_we            frame-buffer write enable
//   mem_addr          frame-buffer address (write address or display address)
//   mem_din           frame-buffer write data
//   busy              a frame render is in progress
//   frame_done        sticky: a complete frame has been stored

module render_scheduler #(
   parameter int H_PIX  = 320,
   parameter int V_PIX  = 240,
   parameter int ADDR_W = 17,
   parameter int PIX_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              shade_start,
   output logic [8:0]        shade_x,
   output logic [8:0]        shade_y,
   input  logic              shade_done,
   input  logic [PIX_W-1:0]  shade_pixel,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_din,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WRITE,
      DONE
   } state_t;

   localparam logic [8:0] X_LAST = 9'(H_PIX - 1);
   localparam logic [8:0] Y_LAST = 9'(V_PIX - 1);

   state_t            state_q, state_d;
   logic [8:0]        x_q, x_d;
   logic [8:0]        y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              frame_done_q, frame_done_d;
   logic              write_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         pix_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         pix_q        <= pix_d;
         frame_done_q <= frame_done_d;
      end
   end

   // addr_q tracks y*H_PIX+x incrementally, so pixels are written in raster
   // order without a multiplier; it is cleared whenever x and y are cleared.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      addr_d       = addr_q;
      pix_d        = pix_q;
      frame_done_d = frame_done_q;
      write_ok     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = ISSUE;
               x_d          = '0;
               y_d          = '0;
               addr_d       = '0;
               frame_done_d = 1'b0;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (shade_done) begin
               pix_d   = shade_pixel;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!disp_req) begin
               write_ok = 1'b1;
               addr_d   = addr_q + ADDR_W'(1);
               state_d  = ISSUE;
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     // Coordinates are rewound here so DONE can restart directly.
                     y_d          = '0;
                     addr_d       = '0;
                     frame_done_d = 1'b1;
                     state_d      = DONE;
                  end else begin
                     y_d = y_q + 9'd1;
                  end
               end else begin
                  x_d = x_q + 9'd1;
               end
            end
         end
         DONE: begin
`ifdef RENDER_CONTINUOUS_EN
            state_d = ISSUE;
`else
            if (start) begin
               state_d      = ISSUE;
               frame_done_d = 1'b0;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The display address passes through whenever no pixel write is taking the port.
   assign shade_start = (state_q == ISSUE);
   assign shade_x     = x_q;
   assign shade_y     = y_q;
   assign mem_we      = write_ok;
   assign mem_addr    = write_ok ? addr_q : disp_addr;
   assign mem_din     = pix_q;
   assign busy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WRITE);
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler
// Directed bench for render_scheduler using a reduced frame height
// (320 x 6) so a complete frame fits in a short run while the row wrap at
// x=319 and the (10,5) abort point are still exercised. The datapath model
// answers every shade_start with shade_done two cycles later. Inputs are
// driven and outputs sampled on the falling clock edge.

module tb_render_scheduler;

   localparam int H  = 320;
   localparam int V  = 6;
   localparam int AW = 17;
   localparam int PW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          shade_done;
   logic [PW-1:0] shade_pixel;
   logic          shade_start;
   logic [8:0]    shade_x;
   logic [8:0]    shade_y;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_din;
   logic          busy;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   render_scheduler #(
      .H_PIX (H),
      .V_PIX (V),
      .ADDR_W(AW),
      .PIX_W (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .shade_start(shade_start),
      .shade_x    (shade_x),
      .shade_y    (shade_y),
      .shade_done (shade_done),
      .shade_pixel(shade_pixel),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Colour returned by the datapath model for a given pixel.
   function automatic logic [PW-1:0] pixVal(input int px, input int py);
      return PW'((px * 7 + py * 13 + 5) & 32'hFFF);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits a bounded number of falling edges for a launch pulse.
   task automatic waitIssue();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (shade_start === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   // Services one pixel: launch check, two-cycle datapath latency, optional
   // display stall with a stray shade_done inside it, then the write check.
   task automatic applyStimulus(input int px, input int py, input int stall, input bit extra_start);
      waitIssue();
      checkOutput("issue_seen", 32'(shade_start), 32'd1);
      checkOutput("shade_x", 32'(shade_x), 32'(px));
      checkOutput("shade_y", 32'(shade_y), 32'(py));
      checkOutput("busy_issue", 32'(busy), 32'd1);
      if (extra_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("wait_no_issue", 32'(shade_start), 32'd0);
      checkOutput("wait_no_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      shade_done  = 1'b1;
      shade_pixel = pixVal(px, py);
      disp_req    = (stall > 0);
      @(negedge clk);
      shade_done  = 1'b0;
      shade_pixel = ~pixVal(px, py);
      for (int s = 0; s < stall; s++) begin
         checkOutput("stall_we", 32'(mem_we), 32'd0);
         checkOutput("stall_addr", 32'(mem_addr), 32'(disp_addr));
         disp_addr  = disp_addr + 17'd977;
         shade_done = (s == 1);
         if (s == stall - 1) disp_req = 1'b0;
         else @(negedge clk);
      end
      shade_done = 1'b0;
      #1;
      checkOutput("write_we", 32'(mem_we), 32'd1);
      checkOutput("write_addr", 32'(mem_addr), 32'(py * H + px));
      checkOutput("write_din", 32'(mem_din), 32'(pixVal(px, py)));
      @(negedge clk);
      checkOutput("post_write_we", 32'(mem_we), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      disp_req    = 1'b0;
      disp_addr   = 17'd1234;
      shade_done  = 1'b0;
      shade_pixel = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_shade_start", 32'(shade_start), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_din", 32'(mem_din), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd1234);
      rst = 1'b0;
      @(negedge clk);

      // Stray datapath result while idle must be ignored.
      shade_done  = 1'b1;
      shade_pixel = 12'h5A5;
      @(negedge clk);
      shade_done = 1'b0;
      repeat (2) begin
         checkOutput("idle_we", 32'(mem_we), 32'd0);
         checkOutput("idle_issue", 32'(shade_start), 32'd0);
         checkOutput("idle_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end

      // Full frame: stall at (3,0), redundant start at (5,0).
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            applyStimulus(x, y, (x == 3 && y == 0) ? 5 : 0, (x == 5 && y == 0));
         end
      end
      checkOutput("done_frame_done", 32'(frame_done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd0);
      checkOutput("done_issue", 32'(shade_start), 32'd0);
      checkOutput("done_addr", 32'(mem_addr), 32'(disp_addr));
`ifdef RENDER_CONTINUOUS_EN
      @(negedge clk);
      checkOutput("cont_issue", 32'(shade_start), 32'd1);
      checkOutput("cont_x", 32'(shade_x), 32'd0);
      checkOutput("cont_y", 32'(shade_y), 32'd0);
      checkOutput("cont_busy", 32'(busy), 32'd1);
      checkOutput("cont_frame_done", 32'(frame_done), 32'd1);
`else
      repeat (4) @(negedge clk);
      checkOutput("hold_issue", 32'(shade_start), 32'd0);
      checkOutput("hold_frame_done", 32'(frame_done), 32'd1);
      checkOutput("hold_busy", 32'(busy), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("restart_issue", 32'(shade_start), 32'd1);
      checkOutput("restart_frame_done", 32'(frame_done), 32'd0);
      checkOutput("restart_busy", 32'(busy), 32'd1);
`endif

      // Second frame up to (10,5), then abort with reset while waiting.
      for (int p = 0; p < 5 * H + 10; p++) begin
         applyStimulus(p % H, p / H, 0, 1'b0);
      end
      waitIssue();
      checkOutput("abort_issue", 32'(shade_start), 32'd1);
      checkOutput("abort_x", 32'(shade_x), 32'd10);
      checkOutput("abort_y", 32'(shade_y), 32'd5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_we", 32'(mem_we), 32'd0);
      checkOutput("abort_shade_start", 32'(shade_start), 32'd0);
      checkOutput("abort_frame_done", 32'(frame_done), 32'd0);
      checkOutput("abort_addr", 32'(mem_addr), 32'(disp_addr));
      @(negedge clk);
      rst         = 1'b0;
      shade_done  = 1'b1;
      shade_pixel = 12'hFFF;
      @(negedge clk);
      shade_done = 1'b0;
      repeat (3) begin
         checkOutput("post_abort_we", 32'(mem_we), 32'd0);
         checkOutput("post_abort_busy", 32'(busy), 32'd0);
         checkOutput("post_abort_issue", 32'(shade_start), 32'd0);
         @(negedge clk);
      end

      // A fresh start resumes from the first pixel.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      applyStimulus(0, 0, 0, 1'b0);
      applyStimulus(1, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
